// File: rtl/uart_rx.sv
// uart_rx: 8N1 serial receiver, BAUD_DIV clk per bit, mid-bit sampling.
// Ports: clk, rst (sync, active-high), RX (async serial in, idle high),
//        clr_rdy (consumer ack), rx_data (last byte), rdy (sticky byte-available),
//        frm_err (bad stop bit; present only when UART_RX_FRM_ERR_EN is defined).
module uart_rx #(
    parameter int BAUD_DIV = 109,
    parameter int HALF_DIV = BAUD_DIV / 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       RX,
    input  logic       clr_rdy,
    output logic [7:0] rx_data,
    output logic       rdy
`ifdef UART_RX_FRM_ERR_EN
    ,
    output logic       frm_err
`endif
);

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_e;

    localparam logic [6:0] BAUD_LAST = 7'(BAUD_DIV - 1);
    localparam logic [6:0] HALF_LAST = 7'(HALF_DIV - 1);

    state_e      state_q, state_d;
    logic        rx_meta_q, rx_s_q, rx_p_q;
    logic [6:0]  baud_cnt_q, baud_cnt_d;
    logic [3:0]  bit_cnt_q, bit_cnt_d;
    logic [7:0]  shift_q, shift_d;
    logic [7:0]  rx_data_q, rx_data_d;
    logic        rdy_q, rdy_d;
    logic        fall;
`ifdef UART_RX_FRM_ERR_EN
    logic        frm_err_q, frm_err_d;
`endif

    // Falling edge on the synchronised line; a line held low never re-arms.
    assign fall = rx_p_q & ~rx_s_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            rx_meta_q  <= 1'b1;
            rx_s_q     <= 1'b1;
            rx_p_q     <= 1'b1;
            baud_cnt_q <= '0;
            bit_cnt_q  <= '0;
            shift_q    <= '0;
            rx_data_q  <= '0;
            rdy_q      <= 1'b0;
`ifdef UART_RX_FRM_ERR_EN
            frm_err_q  <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            rx_meta_q  <= RX;
            rx_s_q     <= rx_meta_q;
            rx_p_q     <= rx_s_q;
            baud_cnt_q <= baud_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
            rx_data_q  <= rx_data_d;
            rdy_q      <= rdy_d;
`ifdef UART_RX_FRM_ERR_EN
            frm_err_q  <= frm_err_d;
`endif
        end
    end

    always_comb begin
        state_d    = state_q;
        baud_cnt_d = baud_cnt_q + 7'd1;
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        rx_data_d  = rx_data_q;
        // Acknowledge first so a delivery in the same cycle overrides it.
        rdy_d      = rdy_q & ~clr_rdy;
`ifdef UART_RX_FRM_ERR_EN
        frm_err_d  = frm_err_q & ~clr_rdy;
`endif
        unique case (state_q)
            IDLE: begin
                baud_cnt_d = '0;
                if (fall) begin
                    state_d = START;
                end
            end
            START: begin
                if (baud_cnt_q == HALF_LAST) begin
                    baud_cnt_d = '0;
                    if (rx_s_q) begin
                        state_d = IDLE;
                    end else begin
                        state_d   = DATA;
                        bit_cnt_d = '0;
                    end
                end
            end
            DATA: begin
                if (baud_cnt_q == BAUD_LAST) begin
                    baud_cnt_d = '0;
                    shift_d    = {rx_s_q, shift_q[7:1]};
                    bit_cnt_d  = bit_cnt_q + 4'd1;
                    if (bit_cnt_d == 4'd8) begin
                        state_d = STOP;
                    end
                end
            end
            STOP: begin
                if (baud_cnt_q == BAUD_LAST) begin
                    baud_cnt_d = '0;
                    state_d    = IDLE;
`ifdef UART_RX_FRM_ERR_EN
                    if (rx_s_q) begin
                        rx_data_d = shift_q;
                        rdy_d     = 1'b1;
                        frm_err_d = 1'b0;
                    end else begin
                        frm_err_d = 1'b1;
                    end
`else
                    rx_data_d = shift_q;
                    rdy_d     = 1'b1;
`endif
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign rx_data = rx_data_q;
    assign rdy     = rdy_q;
`ifdef UART_RX_FRM_ERR_EN
    assign frm_err = frm_err_q;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: drives serial frames into uart_rx and checks rdy/rx_data
// (and frm_err when UART_RX_FRM_ERR_EN is defined) every cycle against a frame-level model.
module tb_uart_rx;

    localparam int BIT = 109;
    localparam int FRAME = 10 * BIT;
    // Stop-bit sample lands on the edge that ends step DLV of a frame.
    localparam int DLV = 1037;
`ifdef UART_RX_FRM_ERR_EN
    localparam bit FRM_EN = 1'b1;
`else
    localparam bit FRM_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       RX = 1'b1;
    logic       clr_rdy = 1'b0;
    logic [7:0] rx_data;
    logic       rdy;
`ifdef UART_RX_FRM_ERR_EN
    logic       frm_err;
`endif

    int checks = 0;
    int errors = 0;

    logic [7:0] m_data;
    logic       m_rdy;
    logic       m_frm;

    uart_rx dut (
        .clk     (clk),
        .rst     (rst),
        .RX      (RX),
        .clr_rdy (clr_rdy),
        .rx_data (rx_data),
        .rdy     (rdy)
`ifdef UART_RX_FRM_ERR_EN
        ,
        .frm_err (frm_err)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            if (errors <= 30)
                $display("FAIL %s: got %0h expected %0h at %0t",
                         tag, got, exp, $time);
        end
    endtask

    // One clock: drive inputs, advance the model for this edge, compare.
    task automatic step(input logic rx, input logic clr, input logic r,
                        input logic dlv, input logic [7:0] b,
                        input logic stop);
        RX = rx;
        clr_rdy = clr;
        rst = r;
        @(posedge clk);
        #1;
        if (r) begin
            m_data = 8'h00;
            m_rdy  = 1'b0;
            m_frm  = 1'b0;
        end else begin
            if (clr) begin
                m_rdy = 1'b0;
                m_frm = 1'b0;
            end
            if (dlv) begin
                if (stop || !FRM_EN) begin
                    m_data = b;
                    m_rdy  = 1'b1;
                    m_frm  = 1'b0;
                end else begin
                    m_frm = 1'b1;
                end
            end
        end
        check("rdy", 32'(rdy), 32'(m_rdy));
        check("rx_data", 32'(rx_data), 32'(m_data));
`ifdef UART_RX_FRM_ERR_EN
        check("frm_err", 32'(frm_err), 32'(m_frm));
`endif
    endtask

    task automatic idle(input int n, input int clr_at);
        for (int i = 0; i < n; i++)
            step(1'b1, i == clr_at, 1'b0, 1'b0, 8'h00, 1'b1);
    endtask

    // Full frame; rst_at >= 0 aborts it with a 3-cycle reset, line back high.
    task automatic send(input logic [7:0] b, input logic stop,
                        input int clr_at, input int rst_at);
        int   k;
        logic rx;
        logic r;
        for (int i = 0; i < FRAME; i++) begin
            k = i / BIT;
            if (k == 0)
                rx = 1'b0;
            else if (k == 9)
                rx = stop;
            else
                rx = b[k-1];
            r = 1'b0;
            if (rst_at >= 0 && i >= rst_at) begin
                rx = 1'b1;
                r  = (i < rst_at + 3);
            end
            step(rx, i == clr_at, r, (i == DLV) && (rst_at < 0), b, stop);
        end
    endtask

    initial begin
        logic [7:0] b;
        logic       stop;
        int         sel;
        int         clr_at;
        int         gap;

        for (int i = 0; i < 4; i++)
            step(1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 1'b1);
        idle(10, -1);

        send(8'hA5, 1'b1, -1, -1);
        idle(5, 2);

        send(8'h00, 1'b1, -1, -1);
        send(8'hFF, 1'b1, -1, -1);
        idle(5, 0);

        for (int i = 0; i < 20; i++)
            step(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
        idle(200, -1);

        send(8'h3C, 1'b0, -1, -1);
        idle(10, -1);
        idle(5, 1);

        send(8'h5A, 1'b1, DLV, -1);
        idle(5, 0);

        send(8'hC3, 1'b1, -1, 57 + BIT * 4);
        idle(1200, -1);
        send(8'h81, 1'b1, -1, -1);
        idle(5, -1);

        for (int f = 0; f < 10; f++) begin
            b    = 8'($urandom);
            stop = ($urandom_range(0, 4) != 0);
            sel  = int'($urandom_range(0, 3));
            case (sel)
                0: clr_at = -1;
                1: clr_at = DLV;
                2: clr_at = int'($urandom_range(0, FRAME - 1));
                default: clr_at = DLV + 1;
            endcase
            send(b, stop, clr_at, -1);
            gap = int'($urandom_range(0, 20));
            if (!stop)
                gap += 5;
            if (gap > 0)
                idle(gap, int'($urandom_range(0, 2 * gap)));
        end
        idle(20, -1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
